// File: rtl/regfile_tagged_pkg.sv
// Shared defines for the tagged register file.
// Widths, defaults and polarity constants.
package regfile_tagged_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int AW_DEF    = $clog2(NREG_DEF);
  localparam int TAG_W_DEF = 4;
  localparam int NRD_DEF   = 2;

  localparam logic RST_ON = 1'b1;
  localparam logic EN_ON  = 1'b1;

endpackage

// File: rtl/regfile_tagged_rdport.sv
// One read port: priority mux with commit bypass.
// Rename is never visible here.
module regfile_tagged_rdport
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = AW_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic             cmt_valid,
  input  logic [AW-1:0]    cmt_addr,
  input  logic [TAG_W-1:0] cmt_tag,
  input  logic [XLEN-1:0]  cmt_data,
  input  logic [XLEN-1:0]  st_data,
  input  logic             st_busy,
  input  logic [TAG_W-1:0] st_tag,
  output logic [XLEN-1:0]  data,
  output logic             busy,
  output logic [TAG_W-1:0] tag
);

  // Disabled, reset and x0 read as zero; same-address commit is bypassed.
  always_comb begin
    data = '0;
    busy = 1'b0;
    tag  = '0;
    if (rst != RST_ON && en == EN_ON && addr != '0) begin
      if (cmt_valid && cmt_addr == addr) begin
        data = cmt_data;
        if (st_busy && st_tag != cmt_tag) begin
          busy = 1'b1;
          tag  = st_tag;
        end
      end else begin
        data = st_data;
        busy = st_busy;
        if (st_busy)
          tag = st_tag;
      end
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// Register file with busy/tag rename tracking.
// N read ports, in-order commit, flush, busy count.
module regfile_tagged
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int AW    = $clog2(NREG),
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = NRD_DEF,
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ren_valid,
  input  logic [AW-1:0]        ren_addr,
  input  logic [TAG_W-1:0]     ren_tag,
  input  logic                 cmt_valid,
  input  logic [AW-1:0]        cmt_addr,
  input  logic [TAG_W-1:0]     cmt_tag,
  input  logic [XLEN-1:0]      cmt_data,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAG_W-1:0] rd_tag,
  output logic [CW-1:0]        busy_count
);

  logic [XLEN-1:0]  data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [XLEN-1:0]  data_n [NREG];
  logic [TAG_W-1:0] tag_n  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_n;
  logic [NREG-1:0]  hit_c;
  logic [NREG-1:0]  hit_r;
  logic [CW-1:0]    cnt_n;

  // Per-register commit and rename hits; flush suppresses rename.
  always_comb begin
    hit_c = '0;
    hit_r = '0;
    for (int r = 0; r < NREG; r++) begin
      hit_c[r] = cmt_valid && (cmt_addr == AW'(r));
      hit_r[r] = ren_valid && !flush && (ren_addr == AW'(r));
    end
  end

  // Next state: rename beats release, flush beats everything.
  always_comb begin
    busy_n = '0;
    for (int r = 0; r < NREG; r++) begin
      data_n[r] = '0;
      tag_n[r]  = '0;
      if (r != 0) begin
        data_n[r] = hit_c[r] ? cmt_data : data_q[r];
        tag_n[r]  = hit_r[r] ? ren_tag : tag_q[r];
        if (flush)
          busy_n[r] = 1'b0;
        else if (hit_r[r])
          busy_n[r] = 1'b1;
        else if (hit_c[r] && busy_q[r] && tag_q[r] == cmt_tag)
          busy_n[r] = 1'b0;
        else
          busy_n[r] = busy_q[r];
      end
    end
  end

  // Popcount of next-state busy bits.
  always_comb begin
    cnt_n = '0;
    for (int r = 0; r < NREG; r++)
      cnt_n = cnt_n + CW'(busy_n[r]);
  end

  // State update; reset wins over every other request.
  always_ff @(posedge clk) begin
    if (rst == RST_ON) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= data_n[r];
        tag_q[r]  <= tag_n[r];
      end
      busy_q     <= busy_n;
      busy_count <= cnt_n;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];

    regfile_tagged_rdport #(
      .XLEN  (XLEN),
      .AW    (AW),
      .TAG_W (TAG_W)
    ) u_rd (
      .rst       (rst),
      .en        (rd_en[i]),
      .addr      (a),
      .cmt_valid (cmt_valid),
      .cmt_addr  (cmt_addr),
      .cmt_tag   (cmt_tag),
      .cmt_data  (cmt_data),
      .st_data   (data_q[a]),
      .st_busy   (busy_q[a]),
      .st_tag    (tag_q[a]),
      .data      (rd_data[i*XLEN +: XLEN]),
      .busy      (rd_busy[i]),
      .tag       (rd_tag[i*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_regfile_tagged.sv
// Bench for regfile_tagged: directed table,
// reset corner, random traffic vs array model.
module tb_regfile_tagged;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ren_valid;
  logic [4:0]  ren_addr;
  logic [3:0]  ren_tag;
  logic        cmt_valid;
  logic [4:0]  cmt_addr;
  logic [3:0]  cmt_tag;
  logic [31:0] cmt_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  logic [5:0]  busy_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_tagged dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .ren_valid  (ren_valid),
    .ren_addr   (ren_addr),
    .ren_tag    (ren_tag),
    .cmt_valid  (cmt_valid),
    .cmt_addr   (cmt_addr),
    .cmt_tag    (cmt_tag),
    .cmt_data   (cmt_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .rd_tag     (rd_tag),
    .busy_count (busy_count)
  );

  // Reference model: plain architectural arrays.
  logic [31:0] m_data [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  typedef struct {
    logic        rv;
    logic [4:0]  ra;
    logic [3:0]  rt;
    logic        cv;
    logic [4:0]  ca;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic        fl;
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic        b0;
    logic [3:0]  t0;
    logic [31:0] d1;
    logic        b1;
    logic [3:0]  t1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    int rv, int ra, int rt,
    int cv, int ca, int ct, logic [31:0] cd,
    int fl, int en, int a0, int a1,
    logic [31:0] d0, int b0, int t0,
    logic [31:0] d1, int b1, int t1,
    int cnt);
    vec_t v;
    v.rv = 1'(rv); v.ra = 5'(ra); v.rt = 4'(rt);
    v.cv = 1'(cv); v.ca = 5'(ca); v.ct = 4'(ct);
    v.cd = cd; v.fl = 1'(fl); v.en = 2'(en);
    v.a0 = 5'(a0); v.a1 = 5'(a1);
    v.d0 = d0; v.b0 = 1'(b0); v.t0 = 4'(t0);
    v.d1 = d1; v.b1 = 1'(b1); v.t1 = 4'(t1);
    v.cnt = 6'(cnt);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic rv, logic [4:0] ra,
                       logic [3:0] rt, logic cv,
                       logic [4:0] ca, logic [3:0] ct,
                       logic [31:0] cd, logic fl,
                       logic [1:0] en, logic [4:0] a0,
                       logic [4:0] a1);
    rst = r; ren_valid = rv; ren_addr = ra; ren_tag = rt;
    cmt_valid = cv; cmt_addr = ca; cmt_tag = ct;
    cmt_data = cd; flush = fl; rd_en = en;
    rd_addr = {a1, a0};
  endtask

  // Expected read result from the architectural rules.
  task automatic exp_rd(int p, output logic [31:0] d,
                        output logic b, output logic [3:0] t);
    logic [4:0] a;
    a = rd_addr[p*5 +: 5];
    d = '0; b = 1'b0; t = '0;
    if (!rst && rd_en[p] && a != 0) begin
      if (cmt_valid && cmt_addr == a) begin
        d = cmt_data;
        if (m_busy[a] && m_tag[a] != cmt_tag) begin
          b = 1'b1; t = m_tag[a];
        end
      end else begin
        d = m_data[a];
        b = m_busy[a];
        t = m_busy[a] ? m_tag[a] : 4'd0;
      end
    end
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
    end else begin
      if (cmt_valid && cmt_addr != 0) begin
        m_data[cmt_addr] = cmt_data;
        if (m_busy[cmt_addr] && m_tag[cmt_addr] == cmt_tag &&
            !(ren_valid && ren_addr == cmt_addr))
          m_busy[cmt_addr] = 1'b0;
      end
      if (flush) begin
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end else if (ren_valid && ren_addr != 0) begin
        m_busy[ren_addr] = 1'b1;
        m_tag[ren_addr]  = ren_tag;
      end
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // Randomised traffic compared against the model each cycle.
  task automatic rand_cycle();
    logic [31:0] d;
    logic        b;
    logic [3:0]  t;
    logic [4:0]  a0;
    logic [4:0]  a1;
    a0 = 5'($urandom_range(0, 7));
    a1 = ($urandom % 4 == 0) ? a0 : 5'($urandom);
    drive(1'($urandom % 80 == 0), 1'($urandom),
          5'($urandom_range(0, 7)), 4'($urandom),
          1'($urandom), 5'($urandom_range(0, 7)),
          4'($urandom), $urandom,
          1'($urandom % 25 == 0), 2'($urandom), a0, a1);
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_rd(p, d, b, t);
      chk($sformatf("rnd_d%0d", p), rd_data[p*32 +: 32], d);
      chk($sformatf("rnd_b%0d", p), 32'(rd_busy[p]), 32'(b));
      chk($sformatf("rnd_t%0d", p), 32'(rd_tag[p*4 +: 4]),
          32'(t));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk("rnd_cnt", 32'(busy_count), 32'(m_count()));
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    drive(1'b1, 1'b1, 5'd3, 4'd1, 1'b1, 5'd3, 4'd1,
          32'h1, 1'b0, 2'b11, 5'd5, 5'd5);
    model_edge();
    @(negedge clk);
    #1;
    chk("rst_d0", rd_data[31:0], 32'h0);
    chk("rst_b", 32'(rd_busy), 32'h0);
    chk("rst_t", 32'(rd_tag), 32'h0);
    @(negedge clk);
    chk("rst_cnt", 32'(busy_count), 32'h0);

    // Directed sequence: reads sampled before the edge,
    // busy_count checked after it.
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,3,5,5,
                     32'h0,0,0, 32'h0,0,0, 0));
    tbl.push_back(mk(1,5,3, 0,0,0,32'h0, 0,3,5,5,
                     32'h0,0,0, 32'h0,0,0, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,3,5,5,
                     32'h0,1,3, 32'h0,1,3, 1));
    tbl.push_back(mk(0,0,0, 1,5,3,32'hDEADBEEF, 0,3,5,5,
                     32'hDEADBEEF,0,0, 32'hDEADBEEF,0,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,3,5,5,
                     32'hDEADBEEF,0,0, 32'hDEADBEEF,0,0, 0));
    tbl.push_back(mk(1,7,2, 0,0,0,32'h0, 0,3,7,5,
                     32'h0,0,0, 32'hDEADBEEF,0,0, 1));
    tbl.push_back(mk(1,7,6, 0,0,0,32'h0, 0,3,7,7,
                     32'h0,1,2, 32'h0,1,2, 1));
    tbl.push_back(mk(0,0,0, 1,7,2,32'h11, 0,3,7,7,
                     32'h11,1,6, 32'h11,1,6, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,3,7,7,
                     32'h11,1,6, 32'h11,1,6, 1));
    tbl.push_back(mk(0,0,0, 1,7,6,32'h22, 0,3,7,7,
                     32'h22,0,0, 32'h22,0,0, 0));
    tbl.push_back(mk(1,9,1, 0,0,0,32'h0, 0,3,9,9,
                     32'h0,0,0, 32'h0,0,0, 1));
    tbl.push_back(mk(1,9,4, 1,9,1,32'h55, 0,3,9,9,
                     32'h55,0,0, 32'h55,0,0, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,3,9,9,
                     32'h55,1,4, 32'h55,1,4, 1));
    tbl.push_back(mk(1,1,1, 0,0,0,32'h0, 0,3,9,1,
                     32'h55,1,4, 32'h0,0,0, 2));
    tbl.push_back(mk(1,2,2, 0,0,0,32'h0, 0,3,1,2,
                     32'h0,1,1, 32'h0,0,0, 3));
    tbl.push_back(mk(1,3,3, 0,0,0,32'h0, 0,3,2,3,
                     32'h0,1,2, 32'h0,0,0, 4));
    tbl.push_back(mk(1,4,4, 0,0,0,32'h0, 0,3,3,4,
                     32'h0,1,3, 32'h0,0,0, 5));
    tbl.push_back(mk(1,10,5, 1,2,9,32'h99, 1,3,2,10,
                     32'h99,1,2, 32'h0,0,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,3,2,10,
                     32'h99,0,0, 32'h0,0,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,3,4,1,
                     32'h0,0,0, 32'h0,0,0, 0));
    tbl.push_back(mk(1,0,7, 1,0,7,32'hFFFFFFFF, 0,3,0,0,
                     32'h0,0,0, 32'h0,0,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,3,0,0,
                     32'h0,0,0, 32'h0,0,0, 0));
    tbl.push_back(mk(1,6,5, 0,0,0,32'h0, 0,3,6,6,
                     32'h0,0,0, 32'h0,0,0, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,0,6,6,
                     32'h0,0,0, 32'h0,0,0, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,32'h0, 0,1,6,6,
                     32'h0,1,5, 32'h0,0,0, 1));
    tbl.push_back(mk(0,0,0, 1,6,5,32'hA5A5, 0,3,6,6,
                     32'hA5A5,0,0, 32'hA5A5,0,0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(1'b0, v.rv, v.ra, v.rt, v.cv, v.ca, v.ct,
            v.cd, v.fl, v.en, v.a0, v.a1);
      #1;
      chk($sformatf("v%0d_d0", i), rd_data[31:0], v.d0);
      chk($sformatf("v%0d_b0", i), 32'(rd_busy[0]), 32'(v.b0));
      chk($sformatf("v%0d_t0", i), 32'(rd_tag[3:0]), 32'(v.t0));
      chk($sformatf("v%0d_d1", i), rd_data[63:32], v.d1);
      chk($sformatf("v%0d_b1", i), 32'(rd_busy[1]), 32'(v.b1));
      chk($sformatf("v%0d_t1", i), 32'(rd_tag[7:4]), 32'(v.t1));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("v%0d_cnt", i), 32'(busy_count),
          32'(v.cnt));
      @(negedge clk);
    end

    // Reset mid-operation masks reads and drops all requests.
    drive(1'b1, 1'b1, 5'd8, 4'd3, 1'b1, 5'd9, 4'd4,
          32'h1234, 1'b0, 2'b11, 5'd9, 5'd8);
    #1;
    chk("mr_d", rd_data[31:0], 32'h0);
    chk("mr_b", 32'(rd_busy), 32'h0);
    chk("mr_t", 32'(rd_tag), 32'h0);
    @(posedge clk);
    model_edge();
    #1;
    chk("mr_cnt", 32'(busy_count), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0,
          32'h0, 1'b0, 2'b11, 5'd9, 5'd8);
    #1;
    chk("mr_x9", rd_data[31:0], 32'h0);
    chk("mr_x8b", 32'(rd_busy[1]), 32'h0);
    @(negedge clk);

    for (int n = 0; n < 800; n++)
      rand_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file for the out-of-order RISC-V core. Each register carries a busy bit and the reorder-buffer tag of its latest in-flight producer. Dispatch claims a register through a rename port, in-order commit writes data and releases the claim, and flush drops all claims. Sits between decode/dispatch (read and rename) and the ROB commit stage (write). It extends the single-issue register file with rename tracking, N read ports and an occupancy counter.

## Interface
- XLEN, 32, data width
- NREG, 32, number of registers; power of two, ≥2
- AW, $clog2(NREG), register address width
- TAG_W, 4, ROB tag width
- NRD, 2, number of read ports
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset rst, synchronous, active-high; clock clk
- flush  in  1  mispredict/exception flush; clears all busy bits
- ren_valid  in  1  rename request
- ren_addr  in  AW  destination register being claimed
- ren_tag  in  TAG_W  ROB tag of the new producer
- cmt_valid  in  1  commit write
- cmt_addr  in  AW  committed destination
- cmt_tag  in  TAG_W  ROB tag of the committing instruction
- cmt_data  in  XLEN  committed value
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  flattened read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  flattened read data
- rd_busy  out  NRD  value not yet available
- rd_tag  out  NRD*TAG_W  producer tag, valid when rd_busy=1
- busy_count  out  $clog2(NREG+1)  registered count of busy registers

## Operation
- State per register: data[XLEN], busy, tag[TAG_W]. Register 0 is never written, never busy, and always reads 0.
- Commit (cmt_valid=1, cmt_addr≠0):
  - data[cmt_addr] ← cmt_data unconditionally.
  - busy is cleared only if busy=1 and tag[cmt_addr]==cmt_tag, and no same-cycle rename targets the same address.
- Rename (ren_valid=1, ren_addr≠0, flush=0): busy ← 1 and tag ← ren_tag. Renaming a register that is already busy overwrites the tag.
- Same-cycle rename and commit to the same address: data is written, busy stays 1, tag ← ren_tag.
- Flush: all busy bits ← 0 and tags are left unchanged. Flush overrides rename. A same-cycle commit still writes its data.
- Read port i, combinational, in priority order:
  - rst=1 or rd_en[i]=0: data=0, busy=0, tag=0.
  - addr=0: data=0, busy=0, tag=0.
  - Commit to the same address in this cycle whose tag releases the register: data=cmt_data, busy=0, tag=0 (bypass).
  - Commit to the same address that does not release it: data=cmt_data, busy=1, tag=stored tag.
  - Register busy: data=stored data, busy=1, tag=stored tag.
  - Otherwise: data=stored data, busy=0, tag=0.
- A same-cycle rename is never visible on the read ports. Reads return pre-rename state, so an instruction's sources are read before its own destination is claimed.
- busy_count ← popcount of the next-state busy vector, updated every cycle.

## Timing
- Reads are zero-latency combinational. Rename, commit and flush take effect at the next rising edge.
- busy_count lags the busy state by 0 cycles: it is registered from the next-state vector and therefore always matches the current busy bits.
- Reset: all data, busy and tag bits and busy_count = 0. All read outputs are 0 while rst=1.
- Reset asserted mid-operation overrides everything in that cycle; rename, commit and flush are ignored.
- Simultaneous reads of the same address on several ports return identical results.

## Structure
- The shared defines package holds XLEN, the register address width, TAG_W defaults and the reset/enable polarity constants used across the core.
- Sub-module regfile_tagged_rdport implements the priority mux and bypass for one port and is instantiated NRD times in a generate loop.
- The top level holds the state arrays, the next-state busy logic and the popcount.

## Test plan
- Reset, then read x5 on both ports -> data=0, busy=0, busy_count=0.
- Rename x5 tag 3, next cycle read x5 -> busy=1, tag=3, busy_count=1. Commit x5 tag 3 data 0xDEADBEEF, same-cycle read -> data=0xDEADBEEF, busy=0. Next cycle -> busy_count=0.
- Rename x7 tag 2, then rename x7 tag 6, then commit x7 tag 2 data 0x11 -> data=0x11, busy=1, tag=6. Commit tag 6 data 0x22 -> busy=0, data=0x22.
- Same cycle: rename x9 tag 4 and commit x9 with its current tag, data 0x55 -> next cycle data=0x55, busy=1, tag=4. Same-cycle read of x9 returns pre-rename state.
- Rename x1..x4, then flush with a concurrent rename x10 and commit x2 data 0x99 -> all busy=0, x10 not busy, x2=0x99, busy_count=0.
- Rename/commit to x0 with data 0xFFFFFFFF -> x0 reads 0, busy=0. rd_en=0 on a busy register -> all outputs 0.
